// File: rtl/axis_burst_pkg.sv
// Shared settings for the AXIS burst master/slave pair so both sides agree on burst length.
package axis_burst_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int TRANS_WIDTH = 4;
    localparam int TRANS_LENTH = 2 ** TRANS_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
endpackage

// File: rtl/burst_buf.sv
// Burst payload store: register array cleared on reset, one write port, one combinational read port.
module burst_buf
    import axis_burst_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int trans_width = TRANS_WIDTH,
    parameter int trans_lenth = TRANS_LENTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [trans_width-1:0] wr_addr,
    input  logic [data_width-1:0]  wr_data,
    input  logic [trans_width-1:0] rd_addr,
    output logic [data_width-1:0]  rd_data
);
    logic [trans_lenth-1:0][data_width-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q <= '0;
        else      mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/axis_burst_master.sv
// Fixed-length AXIS burst source: streams the whole buffer in address order on each en request.
module axis_burst_master
    import axis_burst_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int trans_width = TRANS_WIDTH,
    parameter int trans_lenth = TRANS_LENTH
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [data_width-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    input  logic                   en,
    input  logic                   wr_en,
    input  logic [trans_width-1:0] wr_addr,
    input  logic [data_width-1:0]  wr_data,
    output logic                   busy,
    output logic                   done
);
    localparam logic [trans_width-1:0] CNT_LAST = trans_width'(trans_lenth - 1);

    state_e                 state_q, state_d;
    logic [trans_width-1:0] cnt_q, cnt_d;
    logic [data_width-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   load;
    logic                   buf_wr;
    logic [data_width-1:0]  rd_data;

    // Writes only land while idle and not starting, so each burst sends a coherent snapshot.
    assign buf_wr = wr_en && (state_q == IDLE) && !en;

    burst_buf #(
        .data_width (data_width),
        .trans_width(trans_width),
        .trans_lenth(trans_lenth)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (buf_wr),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(cnt_d),
        .rd_data(rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (valid_q && m_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + trans_width'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Covers both the first word and every advance; also handles a one-word burst.
        if (load) last_d = (cnt_d == CNT_LAST);
    end

    always_comb begin
        data_d = data_q;
        if (load) data_d = rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign busy    = (state_q == SEND);
    assign done    = done_q;
endmodule

// File: tb/tb_axis_burst_master.sv
// Scoreboard bench: stimulus pushes whole-burst snapshots of a model buffer; a negedge monitor checks the stream.
module tb_axis_burst_master;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int TL = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, busy, done;
    logic          m_ready = 1'b0;
    logic          en = 1'b0, wr_en = 1'b0;
    logic [TW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    int            vectors = 0;
    int            errs = 0;
    int            pops = 0;
    int            ready_mode = 0;
    int            ph = 0;
    bit            start_pending = 1'b0;
    bit            done_exp = 1'b0;
    logic [DW-1:0] ref_buf [TL];
    exp_t          q [$];

    axis_burst_master dut (
        .clk(clk), .rst(rst), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides from its own queue whether the master is idle.
    task automatic cyc(input bit e, input bit w, input logic [TW-1:0] a, input logic [DW-1:0] d);
        bit idle;
        @(posedge clk);
        start_pending = 1'b0;
        #1;
        en = e; wr_en = w; wr_addr = a; wr_data = d;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = (ph % 4 == 0) || (ph % 4 == 3);
            default: m_ready = 1'($urandom);
        endcase
        ph++;
        idle = (q.size() == 0);
        if (idle && w && !e) ref_buf[a] = d;
        if (idle && e) begin
            for (int i = 0; i < TL; i++) q.push_back('{data: ref_buf[i], last: (i == TL - 1)});
            start_pending = 1'b1;
        end
    endtask

    task automatic fill();
        for (int i = 0; i < TL; i++) cyc(1'b0, 1'b1, TW'(i), 32'hA000_0000 + DW'(i));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || start_pending) && n < 300) begin
            cyc(1'b0, 1'b0, '0, '0);
            n++;
        end
        chk("drain_left", 64'(q.size()), 0);
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   done_nxt;
        bit   exp_busy;
        if (!rst) begin
            done_exp = 1'b0;
        end else begin
            exp_busy = (q.size() != 0) && !start_pending;
            done_nxt = 1'b0;
            chk("done", 64'(done), 64'(done_exp));
            chk("m_valid", 64'(m_valid), 64'(exp_busy));
            chk("busy", 64'(busy), 64'(exp_busy));
            if (m_valid && exp_busy) begin
                e = q[0];
                chk("m_data", 64'(m_data), 64'(e.data));
                chk("m_last", 64'(m_last), 64'(e.last));
                if (m_ready) begin
                    void'(q.pop_front());
                    pops++;
                    done_nxt = e.last;
                end
            end
            done_exp = done_nxt;
        end
    end

    initial begin
        int base, n;
        for (int i = 0; i < TL; i++) ref_buf[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_m_last", 64'(m_last), 0);
        chk("rst_m_data", 64'(m_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        rst = 1'b1;

        // Full-rate burst.
        ready_mode = 0;
        fill();
        cyc(1'b1, 1'b0, '0, '0);
        drain();

        // Backpressure pattern 1,0,0,1 with en poked mid-burst.
        ready_mode = 1; ph = 0;
        cyc(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++) cyc(i == 7, 1'b0, '0, '0);
        drain();

        // Writes mid-burst and coincident with en are dropped.
        ready_mode = 0;
        cyc(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
        drain();
        cyc(1'b1, 1'b0, '0, '0);
        drain();

        // Back-to-back bursts with en held high.
        for (int i = 0; i < 3 * (TL + 1); i++) cyc(1'b1, 1'b0, '0, '0);
        drain();

        // Asynchronous reset after five handshakes.
        cyc(1'b1, 1'b0, '0, '0);
        base = pops; n = 0;
        while (pops - base < 5 && n < 100) begin
            cyc(1'b0, 1'b0, '0, '0);
            n++;
        end
        chk("hs_before_rst", 64'(pops - base), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_m_valid", 64'(m_valid), 0);
        chk("async_m_last", 64'(m_last), 0);
        chk("async_busy", 64'(busy), 0);
        chk("async_done", 64'(done), 0);
        q.delete();
        start_pending = 1'b0;
        for (int i = 0; i < TL; i++) ref_buf[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, '0, '0);
        drain();

        // Randomized traffic and backpressure.
        ready_mode = 2;
        fill();
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 5) == 0, 1'($urandom), TW'($urandom), $urandom);
        ready_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
